// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared definitions for the FIFO write-port arbiter.
//   arb_state_t : FSM state encoding (ST_IDLE / ST_GRANT)
//   STATS_W     : width of one per-requester accepted-word counter
//   CNT_W       : width of the burst counter (covers MAX_BURST up to 15)
//   cnt_inc     : saturating-free increment helper for the burst counter
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;
  localparam int CNT_W   = 4;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + 4'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side and FIFO-write-side signals of the arbiter.
//   Req/Req_data : per-producer request (doubles as valid) and flattened data
//   Gnt          : one-hot grant back to producers
//   Wfull        : FIFO full flag; Winc/Wrdata : FIFO write strobe and data
//   Owner/Busy   : current/last owner index and GRANT indication
//   Stats_cnt    : per-producer accepted-word counters (zero when disabled)
// modport master : the arbiter; modport slave : producers + FIFO environment.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int Data_width = 8,
  parameter int ID_W       = 2
);
  logic [N_REQ-1:0]            Req;
  logic [N_REQ*Data_width-1:0] Req_data;
  logic                        Wfull;
  logic [N_REQ-1:0]            Gnt;
  logic                        Winc;
  logic [Data_width-1:0]       Wrdata;
  logic [ID_W-1:0]             Owner;
  logic                        Busy;
  logic [N_REQ*STATS_W-1:0]    Stats_cnt;

  modport master (
    input  Req, Req_data, Wfull,
    output Gnt, Winc, Wrdata, Owner, Busy, Stats_cnt
  );

  modport slave (
    output Req, Req_data, Wfull,
    input  Gnt, Winc, Wrdata, Owner, Busy, Stats_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// fifo_wr_arbiter_rr_picker: combinational rotate-priority encoder.
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1
//   found : some request is set
//   idx   : first requester found scanning last+1, last+2, ... modulo N_REQ
module fifo_wr_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  // Scan offsets 1..N_REQ from last; the first hit wins, offset N_REQ is last itself.
  always_comb begin
    int              cand_i;
    logic [ID_W-1:0] cand_s;
    found  = 1'b0;
    idx    = {ID_W{1'b0}};
    cand_i = 0;
    cand_s = {ID_W{1'b0}};
    for (int i = 1; i <= N_REQ; i++) begin
      cand_i = (int'(last) + i) % N_REQ;
      cand_s = cand_i[ID_W-1:0];
      if (!found && req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// between N_REQ producers in the write-clock domain.
//   Clk : write-domain clock (same as FIFO Wclk)
//   Rst : asynchronous active-low reset
//   bus : fifo_wr_arbiter_if.master (Req, Req_data, Wfull in;
//         Gnt, Winc, Wrdata, Owner, Busy, Stats_cnt out)
// A grant lasts until MAX_BURST words are accepted or the owner drops Req.
// Wfull stalls the burst without releasing the grant.
// Optional macro ARB_STATS_EN: enables 16-bit wrapping per-requester counters
// of accepted words; without it Stats_cnt is constant zero.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int Data_width = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = 2
) (
  input logic               Clk,
  input logic               Rst,
  fifo_wr_arbiter_if.master bus
);

  arb_state_t       state_r;
  logic [N_REQ-1:0] gnt_r;
  logic             busy_r;
  logic [ID_W-1:0]  owner_r;
  logic [ID_W-1:0]  last_r;
  logic [CNT_W-1:0] count_r;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic             acc_s;
  logic             last_word_s;

  fifo_wr_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (bus.Req),
    .last  (last_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // A word is taken whenever the owner has valid data and the FIFO has room.
  assign acc_s       = (state_r == ST_GRANT) & bus.Req[owner_r] & ~bus.Wfull;
  assign last_word_s = (cnt_inc(count_r) == CNT_W'(MAX_BURST));

  // Arbitration FSM with registered grant, owner, busy and burst count.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      gnt_r   <= {N_REQ{1'b0}};
      busy_r  <= 1'b0;
      owner_r <= {ID_W{1'b0}};
      last_r  <= ID_W'(N_REQ - 1);
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s && !bus.Wfull) begin
            gnt_r   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
            owner_r <= pick_idx_s;
            last_r  <= pick_idx_s;
            busy_r  <= 1'b1;
            count_r <= {CNT_W{1'b0}};
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Dropping Req ends the burst at once; no word is written that cycle.
          if (!bus.Req[owner_r] || (acc_s && last_word_s)) begin
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            state_r <= ST_IDLE;
          end else if (acc_s) begin
            count_r <= cnt_inc(count_r);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          count_r <= {CNT_W{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data follows the owner's slice while granted, zero otherwise.
  always_comb begin
    if (state_r == ST_GRANT) begin
      bus.Wrdata = bus.Req_data[owner_r*Data_width +: Data_width];
    end else begin
      bus.Wrdata = {Data_width{1'b0}};
    end
  end

  assign bus.Winc  = acc_s;
  assign bus.Gnt   = gnt_r;
  assign bus.Busy  = busy_r;
  assign bus.Owner = owner_r;

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][STATS_W-1:0] stats_r;

  // Per-requester accepted-word counters; wrap naturally at 16'hFFFF.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stats_r <= {(N_REQ*STATS_W){1'b0}};
    end else if (acc_s) begin
      stats_r[owner_r] <= stats_r[owner_r] + 16'd1;
    end else begin
      stats_r <= stats_r;
    end
  end

  assign bus.Stats_cnt = stats_r;
`else
  assign bus.Stats_cnt = {(N_REQ*STATS_W){1'b0}};
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with a write scoreboard.
// Expected FIFO writes ({owner, data}) are queued as stimulus is driven and
// popped each time Winc is seen; Gnt/Busy/Winc are checked every cycle.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] sb[$];

  fifo_wr_arbiter_if #(.N_REQ(N), .Data_width(DW), .ID_W(2)) bus ();

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .Data_width (DW),
    .MAX_BURST  (4),
    .ID_W       (2)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    bus.Req_data[k*DW +: DW] = v;
  endtask

  task automatic push(input int n, input logic [1:0] own, input logic [7:0] d);
    for (int i = 0; i < n; i++) sb.push_back({own, d});
  endtask

  // One clock cycle: sample away from the active edge, then advance.
  task automatic cyc(input logic [3:0] eg, input logic ew);
    logic [9:0] e;
    @(negedge clk);
    check("gnt", {60'd0, bus.Gnt}, {60'd0, eg});
    check("busy", {63'd0, bus.Busy}, {63'd0, |eg});
    check("winc", {63'd0, bus.Winc}, {63'd0, ew});
    if (eg == 4'b0000) check("wrdata_idle", {56'd0, bus.Wrdata}, 64'd0);
    if (bus.Winc === 1'b1) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_underflow: observed write %0h with no expected word", bus.Wrdata);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wrdata", {56'd0, bus.Wrdata}, {56'd0, e[7:0]});
        check("owner", {62'd0, bus.Owner}, {62'd0, e[9:8]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    bus.Req      = 4'b0000;
    bus.Req_data = 32'h0;
    bus.Wfull    = 1'b0;
    @(posedge clk);
    #1;
    // Reset values
    check("rst_gnt", {60'd0, bus.Gnt}, 64'd0);
    check("rst_busy", {63'd0, bus.Busy}, 64'd0);
    check("rst_owner", {62'd0, bus.Owner}, 64'd0);
    check("rst_winc", {63'd0, bus.Winc}, 64'd0);
    check("rst_wrdata", {56'd0, bus.Wrdata}, 64'd0);
    check("rst_stats", bus.Stats_cnt, 64'd0);

    // Test 1: single requester, full burst, one idle cycle, re-grant
    bus.Req = 4'b0001;
    set_data(0, 8'hA0);
    rst = 1'b1;
    push(8, 2'd0, 8'hA0);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);
    bus.Req = 4'b0000;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    drained("t1_drain");

    // Test 2: two requesters alternate 0,2,0 from a fresh pointer
    do_reset();
    set_data(0, 8'h11);
    set_data(2, 8'h33);
    bus.Req = 4'b0101;
    push(4, 2'd0, 8'h11);
    push(4, 2'd2, 8'h33);
    push(4, 2'd0, 8'h11);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);
    bus.Req = 4'b0000;
    cyc(4'b0000, 1'b0);
    drained("t2_drain");

    // Test 3: Wfull in IDLE blocks grant; Wfull mid-burst stalls 3 cycles
    set_data(1, 8'h55);
    bus.Req   = 4'b0010;
    bus.Wfull = 1'b1;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    bus.Wfull = 1'b0;
    push(4, 2'd1, 8'h55);
    cyc(4'b0000, 1'b0);
    cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b1);
    bus.Wfull = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b0);
    bus.Wfull = 1'b0;
    cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b1);
    bus.Req = 4'b0000;
    cyc(4'b0000, 1'b0);
    drained("t3_drain");

    // Test 4: owner 3 drops after one word; next grant wraps to 0
    set_data(3, 8'h77);
    set_data(0, 8'h99);
    bus.Req = 4'b1000;
    push(1, 2'd3, 8'h77);
    push(1, 2'd0, 8'h99);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b1);
    bus.Req = 4'b0001;
    cyc(4'b1000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("t4_owner_hold", {62'd0, bus.Owner}, 64'd0);
    cyc(4'b0001, 1'b1);
    bus.Req = 4'b0000;
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    drained("t4_drain");

    // Test 5: reset mid-burst (owner 2 after 2 words), then 0 granted first
    set_data(2, 8'hA5);
    bus.Req = 4'b0100;
    push(2, 2'd2, 8'hA5);
    cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b1);
    cyc(4'b0100, 1'b1);
    drained("t5_pre_drain");
    rst = 1'b0;
    set_data(0, 8'h5A);
    set_data(1, 8'hB1);
    bus.Req = 4'b0011;
    #1;
    check("mid_rst_gnt", {60'd0, bus.Gnt}, 64'd0);
    check("mid_rst_winc", {63'd0, bus.Winc}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.Busy}, 64'd0);
    check("mid_rst_owner", {62'd0, bus.Owner}, 64'd0);
    check("mid_rst_stats", bus.Stats_cnt, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(4, 2'd0, 8'h5A);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);
    bus.Req = 4'b0000;
    cyc(4'b0000, 1'b0);
    drained("t5_drain");

    // Test 6: 16 words from requesters 0 and 1, then statistics
    do_reset();
    set_data(0, 8'hC0);
    set_data(1, 8'hC1);
    bus.Req = 4'b0011;
    cyc(4'b0000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      push(4, 2'(b % 2), (b % 2 == 0) ? 8'hC0 : 8'hC1);
      for (int i = 0; i < 4; i++) cyc(4'b0001 << (b % 2), 1'b1);
      if (b == 3) bus.Req = 4'b0000;
      cyc(4'b0000, 1'b0);
    end
    drained("t6_drain");
`ifdef ARB_STATS_EN
    check("stats_final", bus.Stats_cnt, {16'd0, 16'd0, 16'd8, 16'd8});
`else
    check("stats_final", bus.Stats_cnt, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO (Winc/Wrdata/Wfull) between N_REQ producers in the write-clock domain.
- Grants one producer at a time for a bounded burst.
- Drives the FIFO write strobe and data, and stalls on Wfull.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- Data_width, 8, FIFO word width
- MAX_BURST, 4, max words accepted per grant (1..15)
- ID_W, 2, owner index width, equal to clog2(N_REQ)

Ports:
- Clk  input  1  write-domain clock (same clock as the FIFO Wclk)
- Rst  input  1  asynchronous active-low reset
- Req  input  N_REQ  per-requester request; also marks valid data
- Req_data  input  N_REQ*Data_width  flattened data; requester k occupies bits [k*Data_width +: Data_width]
- Wfull  input  1  FIFO full flag
- Gnt  output  N_REQ  one-hot grant, registered
- Winc  output  1  FIFO write enable
- Wrdata  output  Data_width  FIFO write data
- Owner  output  ID_W  index of current or last owner
- Busy  output  1  high while in GRANT
- Stats_cnt  output  N_REQ*16  per-requester accepted-word counters (see Optional Feature)

Behaviour:
- Reset (Rst=0, async):
  - state=IDLE; Gnt=0, Busy=0, Owner=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - Burst count=0, Stats_cnt=0.
  - Winc=0, Wrdata=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |Req and !Wfull: pick the first k with Req[k]=1, searching last+1, last+2, ... modulo N_REQ.
  - Next cycle: Gnt=onehot(k), Owner=k, last=k, Busy=1, count=0, state=GRANT.
  - Else stay in IDLE.
- GRANT:
  - Accept condition: acc = Req[Owner] & ~Wfull. Combinational: Winc=acc.
  - Wrdata = Req_data slice of Owner while in GRANT; 0 in IDLE.
  - A producer's word is consumed on every rising edge where acc=1. The producer must hold data stable until then (valid/ready, with Gnt&~Wfull as ready).
  - On acc: count=count+1.
  - Exit to IDLE (Gnt=0, Busy=0) at the edge where acc occurs and count+1==MAX_BURST, or where Req[Owner]=0.
- Grant latency:
  - Request in IDLE to Gnt is 1 cycle.
  - Minimum gap between bursts is 1 idle cycle (the re-arbitration cycle).
- Wfull high in GRANT: Winc=0, count holds, grant holds (stall, no timeout). Wfull never causes a write.
- Wfull high in IDLE: no grant issued.
- Owner dropping Req mid-burst: the burst ends immediately; no word is written that cycle.
- Single active requester: re-granted after the idle cycle. No starvation: each requester waits at most N_REQ-1 bursts.
- Req changes of non-owners have no effect during GRANT.
- Reset mid-burst: all outputs return to reset values asynchronously. Any word not yet accepted is not written.

Optional Feature:
- ARB_STATS_EN defined:
  - Stats_cnt[k*16 +: 16] increments on each accepted word from requester k.
  - Counters wrap at 16'hFFFF to 0; reset to 0.
- ARB_STATS_EN undefined: Stats_cnt tied to 0; no counter flops synthesized.

Decomposition:
- Shared package/header (fifo_arb_defs):
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - STATS_W=16.
- Sub-module rr_picker: combinational rotate-priority encoder.
  - Inputs: Req, last.
  - Outputs: found, idx.
  - Instantiated once.
- FSM, burst counter and stats live in fifo_wr_arbiter.

Test Plan:
- Reset release with Req=4'b0001, Wfull=0, Req_data[7:0]=8'hA0 -> Gnt=4'b0001 one cycle later. Four consecutive Winc with Wrdata=8'hA0. Then Gnt=0 for 1 cycle, then re-grant to 0.
- Req=4'b0101 held, distinct data (8'h11 from req 0, 8'h33 from req 2) -> FIFO receives 4x8'h11, 4x8'h33, 4x8'h11 in order. Owner sequence 0,2,0. Exactly one idle cycle between bursts.
- Grant to 1, Wfull raised after 2 accepted words for 3 cycles -> Winc=0 for those 3 cycles, Gnt held. Then 2 more words, then release. Total 4 words.
- Owner 3 drops Req after 1 word with Req[0]=1 -> burst ends; next grant goes to 0 (wrap from 3). Winc never high while Req[3]=0.
- Rst pulled low mid-burst (after 2 words) -> Gnt, Winc, Busy, Owner, Stats_cnt go to 0 immediately. After release, requester 0 is granted first.
- With ARB_STATS_EN: Req=4'b0011 for 16 words total -> Stats_cnt for requester 0 = 8, requester 1 = 8, others 0. Without the macro, Stats_cnt stays 0.
